// File: rtl/nonrestoring_div_param.sv
// nonrestoring_div_param
// ----------------------
// Iterative non-restoring unsigned divider. It computes quotient and
// remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, resolving STEPS
// quotient bits per clock.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   STEPS  quotient bits per clock: 1, 2 or 4 (WIDTH divisible by STEPS)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   dividend   unsigned dividend, sampled at the accepting edge
//   divisor    unsigned divisor, sampled at the accepting edge
//   busy       high while a division is in progress
//   done       one-cycle completion pulse; results are valid from then on
//   quotient   registered quotient, held until the next completion
//   remainder  registered remainder, held until the next completion
//   div0       divisor was zero (valid with done)
//
// Optional feature:
//   NRDIV_DIV0_DETECT_EN  when defined, a zero divisor skips the iteration
//                         phase and completes one cycle after acceptance
//                         with div0=1. When undefined, div0 is tied to 0 and
//                         a zero divisor runs the full iteration.

module nonrestoring_div_param #(
  parameter int WIDTH = 512,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  state_t state;
  state_t state_next;

  // acc is one bit wider than the operands and held in two's complement, so
  // any divisor up to 2^WIDTH-1 fits without overflow.
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] rem_fix;
  logic [CW-1:0]    count;
  logic             accept;
  logic             zero_bypass;
  logic             busy_next;

  assign accept = (state == IDLE) && start;

`ifdef NRDIV_DIV0_DETECT_EN
  logic zero_flag;

  assign zero_bypass = accept && (divisor == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A detected zero divisor jumps straight to FIX with
  // the operands preloaded so that FIX produces the all-ones/dividend result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = zero_bypass ? FIX : ITER;
        end
      end
      ITER: begin
        if (count == CW'(1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // STEPS chained non-restoring iterations. The add/subtract decision uses
  // the sign of the accumulator before the shift; the new quotient bit is
  // the inverted sign after the add/subtract.
  always_comb begin
    logic [WIDTH:0]   a_t;
    logic [WIDTH-1:0] q_t;
    logic             neg;
    a_t = acc;
    q_t = q_reg;
    neg = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      neg = a_t[WIDTH];
      a_t = {a_t[WIDTH-1:0], q_t[WIDTH-1]};
      q_t = {q_t[WIDTH-2:0], 1'b0};
      if (neg) begin
        a_t = a_t + {1'b0, m_reg};
      end else begin
        a_t = a_t - {1'b0, m_reg};
      end
      q_t[0] = ~a_t[WIDTH];
    end
    acc_step = a_t;
    q_step   = q_t;
  end

  // Final correction: a negative accumulator gets the divisor added back.
  assign rem_fix = acc[WIDTH] ? (acc[WIDTH-1:0] + m_reg) : acc[WIDTH-1:0];

  // busy covers ITER and FIX of a real division, never a bypassed one.
  always_comb begin
    busy_next = 1'b0;
    if (state == IDLE) begin
      busy_next = accept && !zero_bypass;
    end else if (state == ITER) begin
      busy_next = 1'b1;
    end
  end

  // Working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      q_reg <= '0;
      m_reg <= '0;
      count <= '0;
    end else if (accept) begin
      m_reg <= divisor;
      count <= CW'(N);
      if (zero_bypass) begin
        acc   <= {1'b0, dividend};
        q_reg <= '1;
      end else begin
        acc   <= '0;
        q_reg <= dividend;
      end
    end else if (state == ITER) begin
      acc   <= acc_step;
      q_reg <= q_step;
      count <= count - 1'b1;
    end
  end

  // Registered outputs; results are latched only on completion in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      busy <= busy_next;
      done <= (state == FIX);
      if (state == FIX) begin
        quotient  <= q_reg;
        remainder <= rem_fix;
      end
    end
  end

`ifdef NRDIV_DIV0_DETECT_EN
  // div0 is remembered from acceptance and published with done; it holds
  // until the next completion of any kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
      div0      <= 1'b0;
    end else begin
      if (accept) begin
        zero_flag <= zero_bypass;
      end
      if (state == FIX) begin
        div0 <= zero_flag;
      end
    end
  end
`else
  assign div0 = 1'b0;
`endif

endmodule
